dmem_arbiter: RTL
=================

# dmem_arbiter

Two-master arbiter that shares the read/write port (port 1) of the dual-port word RAM between the CPU data interface (master 0) and the debug/DMA loader (master 1). Each master uses a valid/ready request handshake and receives a one-cycle response pulse. The arbiter serialises accesses, registers the winning request, drives the RAM port for exactly one cycle, and returns the registered read word. Port 2 (instruction fetch) is untouched.

## Interface
- ADDR_WIDTH, 12, byte-address width of the RAM port (RAM size 2**ADDR_WIDTH bytes)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mN_valid  in  1  master N (N=0,1) request valid
- mN_ready  out  1  master N request accepted this cycle
- mN_addr  in  ADDR_WIDTH  master N byte address
- mN_wdata  in  32  master N write data
- mN_wstrb  in  4  master N byte-write mask; 4'b0000 = read
- mN_rvalid  out  1  one-cycle response pulse to master N
- mN_rdata  out  32  response data, valid only with mN_rvalid
- mem_addr  out  ADDR_WIDTH  to RAM addr_1
- mem_wdata  out  32  to RAM wdata_1
- mem_wenable  out  4  to RAM wenable_1
- mem_rdata  in  32  from RAM rdata_1 (combinational, already shifted by addr[1:0])

## Operation
- FSM states: IDLE, ACCESS. Reset -> IDLE.
- IDLE: if any mN_valid, pick winner; winner's mN_ready = 1 combinationally (other ready = 0). Handshake = valid & ready. On handshake latch addr, wdata, wstrb, owner id; go ACCESS.
- Winner selection: only one valid -> that one. Both valid -> master indicated by prio register; after each grant prio points to the non-winning master (round-robin). prio reset value = 0.
- ACCESS: mem_addr/mem_wdata/mem_wenable driven from latched request; mem_rdata captured into rdata register at end of cycle (RAM read is pre-write value, i.e. read-before-write). Always return to IDLE.
- Response: in the cycle after ACCESS, owner's mN_rvalid = 1 with mN_rdata = captured word; for writes rdata is the old word and serves as write acknowledge. Non-owner rvalid = 0.
- Outside ACCESS: mem_wenable = 4'b0, mem_addr and mem_wdata = 0. mN_ready = 0 in ACCESS.
- Masters must hold valid and payload stable until ready; arbiter does not check violations.
- Reset: state IDLE, prio 0, latched regs 0, rdata 0; all outputs 0 (mem_wenable 0 immediately on rst_n low, so an ACCESS cycle interrupted by reset performs no write unless the clock edge already occurred).

## Timing
- Handshake at edge N-1..N (cycle N), RAM access cycle N+1, rvalid/rdata cycle N+2 (latency 2).
- A new handshake may occur in the same IDLE cycle that carries the previous rvalid; sustained throughput one access per 2 cycles.
- mN_ready is combinational from state, prio and both valids; no combinational path from mem_rdata to any output.
- Write takes effect at the rising edge ending the ACCESS cycle; a read handshaked in the following IDLE cycle sees the new data.

## Structure
- Shared include (dmem_arb_defs.vh): state encodings ST_IDLE/ST_ACCESS, master ids M_CPU=0, M_LOADER=1.
- One sub-module natural: rr_arbiter2 (two requests, prio register, grant vector, advance input). Remainder (FSM, request/response registers, RAM mux) in dmem_arbiter.

## Test plan
- Single read: RAM word 0x10 = 0xDEADBEEF; m0 read addr 0x10 -> m0_ready at cycle 0, mem_addr=0x10 cycle 1, m0_rvalid=1 with 0xDEADBEEF cycle 2, m1_rvalid stays 0.
- Byte write then read: m1 write addr 0x21, wdata 0x000000AA, wstrb 4'b0001 over word 0x11223344 -> mem_wenable=0001 exactly one cycle; subsequent m0 read addr 0x20 returns 0x1122AA44.
- Contention: both valid continuously for 4 grants from reset -> grant order m0, m1, m0, m1; each response to correct master, 2 cycles apart.
- Back-to-back: m0 holds valid with new requests -> new handshake coincides with previous rvalid; no cycle with mem_wenable != 0 outside ACCESS.
- Read-before-write: m0 write 0xCAFEF00D, wstrb 4'b1111 to word holding 0x0 -> m0_rdata on rvalid = 0x0.
- Reset mid-op: assert rst_n low during ACCESS of a write -> mem_wenable drops to 0 asynchronously, target word unchanged, all ready/rvalid 0, after release m0 wins first.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arbiter_pkg;
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic M_CPU    = 1'b0;
    localparam logic M_LOADER = 1'b1;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;
    localparam int NUM_MASTERS = 2;
endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-request round-robin arbiter: grants the lone requester, or the prio
// master on contention; prio moves to the loser whenever a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = prio_reg ? 2'b10 : 2'b01;
    end

    // grant[0] set means master 0 won, so master 1 gets priority next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_reg <= 1'b0;
        else if (advance)
            prio_reg <= grant[0];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares RAM port 1 between the CPU data master (0) and the loader (1):
// one registered request, one RAM cycle, one response pulse per access.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wenable,
    input  logic [31:0]           mem_rdata
);
    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [STRB_WIDTH-1:0]   wstrb_reg;
    logic                    owner_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic [NUM_MASTERS-1:0]  rvalid_reg;

    logic [NUM_MASTERS-1:0]  valid_vec;
    logic [NUM_MASTERS-1:0]  grant_vec;
    logic [NUM_MASTERS-1:0]  ready_vec;
    logic                    handshake;
    logic                    winner;
    logic                    in_access;

    assign valid_vec = {m1_valid, m0_valid};
    assign in_access = (state_reg == ST_ACCESS);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (valid_vec),
        .advance (handshake),
        .grant   (grant_vec)
    );

    // Grant is a subset of valid, so any ready bit is a completed handshake.
    // Reset holds ready low even though the FSM already sits in IDLE.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_ready
            assign ready_vec[gi] = rst_n && !in_access && grant_vec[gi];
        end
    endgenerate

    assign handshake = |ready_vec;
    assign winner    = ready_vec[1] ? M_LOADER : M_CPU;

    assign m0_ready  = ready_vec[0];
    assign m1_ready  = ready_vec[1];
    assign m0_rvalid = rvalid_reg[0];
    assign m1_rvalid = rvalid_reg[1];
    assign m0_rdata  = rdata_reg;
    assign m1_rdata  = rdata_reg;

    // Gated by state so an async reset kills an in-flight write strobe at once
    assign mem_addr    = in_access ? addr_reg  : '0;
    assign mem_wdata   = in_access ? wdata_reg : '0;
    assign mem_wenable = in_access ? wstrb_reg : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            owner_reg  <= M_CPU;
            rdata_reg  <= '0;
            rvalid_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    rvalid_reg <= '0;
                    if (handshake) begin
                        addr_reg  <= (winner == M_LOADER) ? m1_addr  : m0_addr;
                        wdata_reg <= (winner == M_LOADER) ? m1_wdata : m0_wdata;
                        wstrb_reg <= (winner == M_LOADER) ? m1_wstrb : m0_wstrb;
                        owner_reg <= winner;
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdata_reg  <= mem_rdata;
                    rvalid_reg <= (owner_reg == M_LOADER) ? 2'b10 : 2'b01;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule
